// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router control path: FSM state encodings and
// destination port addresses.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        CHECK_PARITY_ERROR = 3'd4,
        FIFO_FULL_STATE    = 3'd5,
        LOAD_AFTER_FULL    = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    localparam logic [1:0] ADDR0 = 2'd0;
    localparam logic [1:0] ADDR1 = 2'd1;
    localparam logic [1:0] ADDR2 = 2'd2;

endpackage

// File: rtl/router_ctrl_fsm.sv
// Control FSM of the 1x3 packet router: decodes the header address and sequences
// header, payload and parity loading, full stalls and destination drain waits.
module router_ctrl_fsm
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       write_enb_reg,
    output logic       detect_add,
    output logic       ld_state,
    output logic       laf_state,
    output logic       lfd_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy
);

    state_t     state;
    state_t     next_state;
    logic [1:0] addr;
    logic       empty_in;
    logic       empty_addr;
    logic       soft_hit;

    // Per-port selects: incoming header address and the latched packet address
    always_comb begin
        empty_in   = 1'b0;
        empty_addr = 1'b0;
        soft_hit   = 1'b0;
        case (data_in)
            ADDR0:   empty_in = fifo_empty_0;
            ADDR1:   empty_in = fifo_empty_1;
            ADDR2:   empty_in = fifo_empty_2;
            default: empty_in = 1'b0;
        endcase
        case (addr)
            ADDR0: begin
                empty_addr = fifo_empty_0;
                soft_hit   = soft_reset_0;
            end
            ADDR1: begin
                empty_addr = fifo_empty_1;
                soft_hit   = soft_reset_1;
            end
            ADDR2: begin
                empty_addr = fifo_empty_2;
                soft_hit   = soft_reset_2;
            end
            default: begin
                empty_addr = 1'b0;
                soft_hit   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            state <= DECODE_ADDRESS;
            addr  <= ADDR0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && next_state != DECODE_ADDRESS)
                addr <= data_in;
        end
    end

    always_comb begin
        next_state = state;
        if (state != DECODE_ADDRESS && soft_hit) begin
            next_state = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS:
                    if (pkt_valid && data_in != 2'd3)
                        next_state = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                LOAD_FIRST_DATA:
                    next_state = LOAD_DATA;
                LOAD_DATA:
                    if (fifo_full)       next_state = FIFO_FULL_STATE;
                    else if (!pkt_valid) next_state = LOAD_PARITY;
                LOAD_PARITY:
                    next_state = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR:
                    next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                FIFO_FULL_STATE:
                    if (!fifo_full) next_state = LOAD_AFTER_FULL;
                LOAD_AFTER_FULL:
                    if (parity_done)        next_state = DECODE_ADDRESS;
                    else if (low_pkt_valid) next_state = LOAD_PARITY;
                    else                    next_state = LOAD_DATA;
                WAIT_TILL_EMPTY:
                    if (empty_addr) next_state = LOAD_FIRST_DATA;
                default:
                    next_state = DECODE_ADDRESS;
            endcase
        end
    end

    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b1;
        case (state)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
            end
            LOAD_FIRST_DATA:    lfd_state = 1'b1;
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
            end
            LOAD_PARITY:        write_enb_reg = 1'b1;
            CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
            FIFO_FULL_STATE:    full_state = 1'b1;
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Scoreboard bench for router_ctrl_fsm: directed packet scenarios followed by
// randomized traffic, checked against a behavioural model of the router rules.
module tb_router_ctrl_fsm;

    logic       clock = 1'b0;
    logic       resetn, pkt_valid, fifo_full, parity_done, low_pkt_valid;
    logic [1:0] data_in;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       write_enb_reg, detect_add, ld_state, laf_state, lfd_state;
    logic       full_state, rst_int_reg, busy;

    router_ctrl_fsm dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0),
        .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .write_enb_reg(write_enb_reg), .detect_add(detect_add), .ld_state(ld_state),
        .laf_state(laf_state), .lfd_state(lfd_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .busy(busy)
    );

    always #5 clock = ~clock;

    // Phase numbers are the fixed state encodings of the router
    localparam int IDLE = 0, HDR = 1, PAY = 2, PAR = 3, CHK = 4, FULL = 5, AFT = 6, WAIT = 7;

    typedef struct {
        logic [7:0] outs;
        int         phase;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   m_phase = IDLE;
    int   m_port = 0;

    // Output order: write_enb, detect_add, ld, laf, lfd, full, rst_int, busy
    function automatic logic [7:0] expect_outs(input int p);
        logic [7:0] o;
        o[7] = (p == PAY || p == PAR || p == AFT);
        o[6] = (p == IDLE);
        o[5] = (p == PAY);
        o[4] = (p == AFT);
        o[3] = (p == HDR);
        o[2] = (p == FULL);
        o[1] = (p == CHK);
        o[0] = !(p == IDLE || p == PAY);
        return o;
    endfunction

    function automatic void model_advance();
        logic [2:0] empty = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
        logic [2:0] sreset = {soft_reset_2, soft_reset_1, soft_reset_0};
        int nxt = m_phase;
        if (resetn) begin
            nxt = IDLE;
            m_port = 0;
        end else if (m_phase != IDLE && sreset[m_port]) begin
            nxt = IDLE;
        end else if (m_phase == IDLE) begin
            if (pkt_valid && data_in != 2'd3) begin
                m_port = int'(data_in);
                nxt = empty[m_port] ? HDR : WAIT;
            end
        end else if (m_phase == HDR) nxt = PAY;
        else if (m_phase == PAY) nxt = fifo_full ? FULL : (pkt_valid ? PAY : PAR);
        else if (m_phase == PAR) nxt = CHK;
        else if (m_phase == CHK) nxt = fifo_full ? FULL : IDLE;
        else if (m_phase == FULL) nxt = fifo_full ? FULL : AFT;
        else if (m_phase == AFT) nxt = parity_done ? IDLE : (low_pkt_valid ? PAR : PAY);
        else if (m_phase == WAIT) nxt = empty[m_port] ? HDR : WAIT;
        m_phase = nxt;
    endfunction

    task automatic tick();
        exp_t e;
        model_advance();
        e.outs  = expect_outs(m_phase);
        e.phase = m_phase;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [7:0] got;
            e = exp_q.pop_front();
            got = {write_enb_reg, detect_add, ld_state, laf_state, lfd_state,
                   full_state, rst_int_reg, busy};
            vectors++;
            if (got !== e.outs || int'(dut.state) != e.phase) begin
                miscompares++;
                $display("FAIL vec%0d outputs/state: got %b state %0d, want %b state %0d",
                         vectors, got, dut.state, e.outs, e.phase);
            end
        end
    end

    initial begin
        idle_inputs();
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        tick();

        // Clean packet to port 0
        pkt_valid = 1'b1; data_in = 2'd0;
        tick(); tick();
        pkt_valid = 1'b0;
        tick(); tick(); tick(); tick();

        // Full stall on port 1, exit via low_pkt_valid, plain resume, then parity_done
        pkt_valid = 1'b1; data_in = 2'd1;
        tick(); tick();
        fifo_full = 1'b1; tick(); tick();
        fifo_full = 1'b0; low_pkt_valid = 1'b1; tick(); tick();
        low_pkt_valid = 1'b0; tick(); tick(); tick();
        pkt_valid = 1'b1; tick(); tick();
        fifo_full = 1'b1; tick();
        fifo_full = 1'b0; tick(); tick();
        fifo_full = 1'b1; tick();
        fifo_full = 1'b0; parity_done = 1'b1; tick(); tick();
        parity_done = 1'b0; pkt_valid = 1'b0; tick();

        // Busy destination 2; data_in changes are ignored while waiting
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
        tick();
        data_in = 2'd0; tick(); tick();
        fifo_empty_2 = 1'b1; tick(); tick();
        resetn = 1'b1; tick(); resetn = 1'b0;

        // Soft reset on a foreign port is ignored, on the own port aborts
        data_in = 2'd1; tick(); tick();
        soft_reset_0 = 1'b1; tick(); tick();
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b1; tick();
        soft_reset_1 = 1'b0; data_in = 2'd3; tick(); tick();

        // Reset while stalled full
        data_in = 2'd2; tick(); tick();
        fifo_full = 1'b1; tick(); tick();
        resetn = 1'b1; tick();
        idle_inputs(); tick();

        for (int i = 0; i < 600; i++) begin
            resetn        = ($urandom_range(0, 40) == 0);
            pkt_valid     = ($urandom_range(0, 3) != 0);
            data_in       = 2'($urandom_range(0, 3));
            fifo_full     = ($urandom_range(0, 3) == 0);
            fifo_empty_0  = ($urandom_range(0, 2) != 0);
            fifo_empty_1  = ($urandom_range(0, 2) != 0);
            fifo_empty_2  = ($urandom_range(0, 2) != 0);
            soft_reset_0  = ($urandom_range(0, 15) == 0);
            soft_reset_1  = ($urandom_range(0, 15) == 0);
            soft_reset_2  = ($urandom_range(0, 15) == 0);
            parity_done   = ($urandom_range(0, 3) == 0);
            low_pkt_valid = ($urandom_range(0, 2) == 0);
            tick();
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
